// File: rtl/div_hilo_unit_if.sv
// ============================================================================
// Module   : div_hilo_unit_if
// Purpose  : E-stage divide request, M-stage HI/LO write and HI/LO read bundle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface div_hilo_unit_if;
   logic        DivStartE;
   logic        DivSignedE;
   logic [31:0] SrcAE;
   logic [31:0] SrcBE;
   logic        FlushE;
   logic        HiWeM;
   logic        LoWeM;
   logic [31:0] ALUOutHighM;
   logic [31:0] ALUOutM;
   logic [31:0] HiOut;
   logic [31:0] LoOut;
   logic        DivBusyE;
   logic        DivDoneE;

   modport master (
      output DivStartE, DivSignedE, SrcAE, SrcBE, FlushE,
      output HiWeM, LoWeM, ALUOutHighM, ALUOutM,
      input  HiOut, LoOut, DivBusyE, DivDoneE
   );

   modport slave (
      input  DivStartE, DivSignedE, SrcAE, SrcBE, FlushE,
      input  HiWeM, LoWeM, ALUOutHighM, ALUOutM,
      output HiOut, LoOut, DivBusyE, DivDoneE
   );
endinterface

`default_nettype wire

// File: rtl/div_hilo_unit.sv
// ============================================================================
// Module   : div_hilo_unit
// Purpose  : Iterative 32-bit DIV/DIVU (radix-2 restoring) with HI/LO registers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_hilo_unit (
   input  logic            clock,
   input  logic            reset,
   div_hilo_unit_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_DIVZERO = 2'd1,
      ST_RUN     = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [4:0]  r_count;
   logic [31:0] r_rem;
   logic [31:0] r_quo;
   logic [31:0] r_dvsr;
   logic        r_qneg;
   logic        r_rneg;
   logic [31:0] r_hi;
   logic [31:0] r_lo;

   logic        w_accept;
   logic        w_busy;
   logic        w_done;
   logic        w_div_wr;
   logic [31:0] w_abs_a;
   logic [31:0] w_abs_b;
   logic [32:0] w_shift;
   logic [32:0] w_trial;
   logic [31:0] w_quo_fin;
   logic [31:0] w_rem_fin;

   // Gated by reset so the stall request reads 0 while reset is held.
   assign w_accept = reset && (r_state == ST_IDLE) && bus.DivStartE && !bus.FlushE;

   assign w_abs_a = (bus.DivSignedE && bus.SrcAE[31]) ? (32'd0 - bus.SrcAE) : bus.SrcAE;
   assign w_abs_b = (bus.DivSignedE && bus.SrcBE[31]) ? (32'd0 - bus.SrcBE) : bus.SrcBE;

   // 33-bit partial remainder; bit 32 of the trial is the restore decision.
   assign w_shift = {r_rem, r_quo[31]};
   assign w_trial = w_shift - {1'b0, r_dvsr};

   assign w_quo_fin = r_qneg ? (32'd0 - r_quo) : r_quo;
   assign w_rem_fin = r_rneg ? (32'd0 - r_rem) : r_rem;
   assign w_div_wr  = (r_state == ST_DONE) && !bus.FlushE;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      w_busy = 1'b0;
      w_done = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_busy = 1'b1;
               w_next = (bus.SrcBE == 32'd0) ? ST_DIVZERO : ST_RUN;
            end
         end
         ST_RUN: begin
            w_busy = 1'b1;
            if (r_count == 5'd31) begin
               w_next = ST_DONE;
            end
         end
         ST_DONE: begin
            w_done = !bus.FlushE;
            w_next = ST_IDLE;
         end
         ST_DIVZERO: begin
            w_done = !bus.FlushE;
            w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
      if (bus.FlushE) begin
         w_next = ST_IDLE;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_count <= 5'd0;
         r_rem   <= 32'd0;
         r_quo   <= 32'd0;
         r_dvsr  <= 32'd0;
         r_qneg  <= 1'b0;
         r_rneg  <= 1'b0;
      end else if (w_accept) begin
         r_count <= 5'd0;
         r_rem   <= 32'd0;
         r_quo   <= w_abs_a;
         r_dvsr  <= w_abs_b;
         r_qneg  <= bus.DivSignedE && (bus.SrcAE[31] ^ bus.SrcBE[31]);
         r_rneg  <= bus.DivSignedE && bus.SrcAE[31];
      end else if (r_state == ST_RUN) begin
         r_count <= r_count + 5'd1;
         r_rem   <= w_trial[32] ? w_shift[31:0] : w_trial[31:0];
         r_quo   <= {r_quo[30:0], ~w_trial[32]};
      end
   end

   // The divide result is the younger instruction, so it beats MTHI/MTLO.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_hi <= 32'd0;
         r_lo <= 32'd0;
      end else if (w_div_wr) begin
         r_hi <= w_rem_fin;
         r_lo <= w_quo_fin;
      end else begin
         if (bus.HiWeM) r_hi <= bus.ALUOutHighM;
         if (bus.LoWeM) r_lo <= bus.ALUOutM;
      end
   end

   assign bus.HiOut    = r_hi;
   assign bus.LoOut    = r_lo;
   assign bus.DivBusyE = w_busy;
   assign bus.DivDoneE = w_done;

endmodule

`default_nettype wire

// File: tb/tb_div_hilo_unit.sv
// ============================================================================
// Module   : tb_div_hilo_unit
// Purpose  : Vector table plus scoreboarded sequences for div_hilo_unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_hilo_unit;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
   } exp_t;

   typedef struct {
      logic        sg;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   exp_t        sb[$];
   vec_t        vecs[10];
   logic [31:0] m_hi;
   logic [31:0] m_lo;

   div_hilo_unit_if bus ();

   div_hilo_unit dut (
      .clock (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Issues one divide, measures busy/done timing, then checks HI/LO
   // against the scoreboard entry pushed when the request was driven.
   task automatic run_div(input string tag, input logic sg, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh,
                          input logic [31:0] el, input logic hiwe);
      int   busy_n;
      int   done_at;
      int   exp_cyc;
      exp_t e;
      exp_cyc = (b == 32'd0) ? 1 : 33;
      @(negedge clk);
      bus.DivStartE  = 1'b1;
      bus.DivSignedE = sg;
      bus.SrcAE      = a;
      bus.SrcBE      = b;
      sb.push_back('{hi: eh, lo: el});
      busy_n  = 0;
      done_at = -1;
      #1;
      for (int n = 0; n < 45; n++) begin
         if (n > 0) @(negedge clk);
         if (bus.DivBusyE) busy_n++;
         if (bus.DivDoneE) begin
            done_at       = n;
            bus.DivStartE = 1'b0;
            if (hiwe) bus.HiWeM = 1'b1;
            break;
         end
      end
      bus.DivStartE = 1'b0;
      check({tag, " done_cycle"}, done_at, exp_cyc);
      check({tag, " busy_cycles"}, busy_n, exp_cyc);
      @(posedge clk);
      #1;
      bus.HiWeM = 1'b0;
      if (sb.size() == 0) begin
         check({tag, " scoreboard_empty"}, 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         check({tag, " HI"}, bus.HiOut, e.hi);
         check({tag, " LO"}, bus.LoOut, e.lo);
      end
   endtask

   initial begin
      int          seen;
      int          sa;
      int          sbv;
      logic [31:0] ra;
      logic [31:0] rb;
      logic [31:0] eh;
      logic [31:0] el;

      checks = 0;
      errors = 0;
      vecs[0] = '{sg: 1'b0, a: 32'd100,        b: 32'd7,        hi: 32'h00000002, lo: 32'h0000000E};
      vecs[1] = '{sg: 1'b1, a: 32'hFFFFFFF9,   b: 32'h00000002, hi: 32'hFFFFFFFF, lo: 32'hFFFFFFFD};
      vecs[2] = '{sg: 1'b1, a: 32'h80000000,   b: 32'hFFFFFFFF, hi: 32'h00000000, lo: 32'h80000000};
      vecs[3] = '{sg: 1'b0, a: 32'hFFFFFFFF,   b: 32'h00000010, hi: 32'h0000000F, lo: 32'h0FFFFFFF};
      vecs[4] = '{sg: 1'b1, a: 32'h00000007,   b: 32'hFFFFFFFE, hi: 32'h00000001, lo: 32'hFFFFFFFD};
      vecs[5] = '{sg: 1'b0, a: 32'h80000000,   b: 32'hFFFFFFFF, hi: 32'h80000000, lo: 32'h00000000};
      vecs[6] = '{sg: 1'b1, a: 32'hFFFFFF9C,   b: 32'hFFFFFFF9, hi: 32'hFFFFFFFE, lo: 32'h0000000E};
      vecs[7] = '{sg: 1'b1, a: 32'h00000000,   b: 32'h00000005, hi: 32'h00000000, lo: 32'h00000000};
      vecs[8] = '{sg: 1'b0, a: 32'h00000001,   b: 32'h00000001, hi: 32'h00000000, lo: 32'h00000001};
      vecs[9] = '{sg: 1'b0, a: 32'hDEADBEEF,   b: 32'h00010000, hi: 32'h0000BEEF, lo: 32'h0000DEAD};

      bus.DivStartE   = 1'b1;
      bus.DivSignedE  = 1'b0;
      bus.SrcAE       = 32'd9;
      bus.SrcBE       = 32'd3;
      bus.FlushE      = 1'b0;
      bus.HiWeM       = 1'b0;
      bus.LoWeM       = 1'b0;
      bus.ALUOutHighM = 32'd0;
      bus.ALUOutM     = 32'd0;
      rst_n           = 1'b0;
      m_hi            = 32'd0;
      m_lo            = 32'd0;

      // Reset state, with a request already pending on the bus.
      #12;
      check("reset HI", bus.HiOut, 32'd0);
      check("reset LO", bus.LoOut, 32'd0);
      check("reset busy", {31'd0, bus.DivBusyE}, 32'd0);
      check("reset done", {31'd0, bus.DivDoneE}, 32'd0);
      bus.DivStartE = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         run_div($sformatf("vec%0d", i), vecs[i].sg, vecs[i].a, vecs[i].b,
                 vecs[i].hi, vecs[i].lo, 1'b0);
         m_hi = vecs[i].hi;
         m_lo = vecs[i].lo;
      end

      // MTHI/MTLO then divide by zero leaves HI/LO untouched.
      @(negedge clk);
      bus.HiWeM = 1'b1; bus.ALUOutHighM = 32'h11;
      bus.LoWeM = 1'b1; bus.ALUOutM     = 32'h22;
      @(negedge clk);
      bus.HiWeM = 1'b0; bus.LoWeM = 1'b0;
      m_hi = 32'h11; m_lo = 32'h22;
      check("mthi HI", bus.HiOut, m_hi);
      check("mtlo LO", bus.LoOut, m_lo);
      run_div("divzero", 1'b1, 32'd5, 32'd0, m_hi, m_lo, 1'b0);

      // Flush during RUN: no completion, no write, next divide normal.
      @(negedge clk);
      bus.DivStartE = 1'b1; bus.DivSignedE = 1'b0;
      bus.SrcAE = 32'd1000; bus.SrcBE = 32'd3;
      repeat (10) @(negedge clk);
      check("flush busy_in_run", {31'd0, bus.DivBusyE}, 32'd1);
      bus.FlushE = 1'b1; bus.DivStartE = 1'b0;
      @(negedge clk);
      bus.FlushE = 1'b0;
      check("flush busy_after", {31'd0, bus.DivBusyE}, 32'd0);
      seen = 0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (bus.DivDoneE) seen++;
      end
      check("flush no_done", seen, 32'd0);
      check("flush HI", bus.HiOut, m_hi);
      check("flush LO", bus.LoOut, m_lo);
      run_div("post_flush", 1'b0, 32'd1000, 32'd3, 32'd1, 32'd333, 1'b0);
      m_hi = 32'd1; m_lo = 32'd333;

      // MTHI colliding with DONE: divider wins; then MTHI alone in IDLE.
      bus.ALUOutHighM = 32'hAAAA0000;
      run_div("collide", 1'b0, 32'd9, 32'd4, 32'd1, 32'd2, 1'b1);
      @(negedge clk);
      bus.HiWeM = 1'b1;
      @(negedge clk);
      bus.HiWeM = 1'b0;
      m_hi = 32'hAAAA0000; m_lo = 32'd2;
      check("mthi_idle HI", bus.HiOut, m_hi);
      check("mthi_idle LO", bus.LoOut, m_lo);

      // Reset mid-RUN: outputs clear at once, operation never completes.
      @(negedge clk);
      bus.DivStartE = 1'b1; bus.DivSignedE = 1'b0;
      bus.SrcAE = 32'h12345678; bus.SrcBE = 32'd3;
      repeat (20) @(negedge clk);
      bus.DivStartE = 1'b0;
      rst_n = 1'b0;
      #1;
      check("midrst HI", bus.HiOut, 32'd0);
      check("midrst LO", bus.LoOut, 32'd0);
      check("midrst busy", {31'd0, bus.DivBusyE}, 32'd0);
      check("midrst done", {31'd0, bus.DivDoneE}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      m_hi = 32'd0; m_lo = 32'd0;
      seen = 0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (bus.DivDoneE) seen++;
      end
      check("midrst no_done", seen, 32'd0);
      check("midrst HI_after", bus.HiOut, 32'd0);
      check("midrst LO_after", bus.LoOut, 32'd0);
      run_div("ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0);

      // Random operands, expected values from the language's own / and %.
      for (int i = 0; i < 6; i++) begin
         ra = $urandom;
         rb = $urandom >> (i * 5);
         if (rb == 32'd0) rb = 32'd3;
         if (i % 2 == 1) begin
            if (ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'd7;
            sa  = ra;
            sbv = rb;
            el  = sa / sbv;
            eh  = sa % sbv;
         end else begin
            el = ra / rb;
            eh = ra % rb;
         end
         run_div($sformatf("rnd%0d", i), (i % 2 == 1), ra, rb, eh, el, 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/div_hilo_unit.md
DIV_HILO_UNIT -- requirements
Module: div_hilo_unit

Interface
REQ-001 SHALL have port: clock  in  1  single clock; all state changes on its rising edge.
REQ-002 SHALL have port: reset  in  1  asynchronous, active-low (0 = reset asserted).
REQ-003 SHALL have port: DivStartE  in  1  E-stage DIV/DIVU request; level, held by the pipeline while stalled.
REQ-004 SHALL have port: DivSignedE  in  1  1 = DIV (signed), 0 = DIVU; sampled with DivStartE.
REQ-005 SHALL have port: SrcAE  in  32  dividend; SrcBE  in  32  divisor; both sampled at accept.
REQ-006 SHALL have port: FlushE  in  1  exception/flush; cancels any divide in progress.
REQ-007 SHALL have port: HiWeM  in  1  and LoWeM  in  1  independent HI/LO write enables (MTHI/MTLO commit).
REQ-008 SHALL have port: ALUOutHighM  in  32  HI write data; ALUOutM  in  32  LO write data.
REQ-009 SHALL have port: HiOut  out  32  and LoOut  out  32  current HI/LO register values.
REQ-010 SHALL have port: DivBusyE  out  1  stall request to hazard unit; DivDoneE  out  1  one-cycle completion strobe.

Function
REQ-011 SHALL implement FSM states IDLE, DIVZERO, RUN, DONE; reset state IDLE.
REQ-012 IDLE: DivStartE=1, FlushE=0, SrcBE!=0 -> RUN; SrcBE=0 -> DIVZERO; otherwise stay IDLE.
REQ-013 On accept SHALL latch |SrcAE|, |SrcBE| (absolute values only when DivSignedE=1), quotient sign = SrcAE[31]^SrcBE[31], remainder sign = SrcAE[31] (signed only).
REQ-014 RUN SHALL perform one radix-2 restoring step per cycle on a 33-bit partial remainder, 5-bit counter 0..31; after step 31 -> DONE.
REQ-015 DONE SHALL apply sign correction (two's-complement negate), assert DivDoneE=1, write LO=quotient, HI=remainder on the edge ending DONE, -> IDLE.
REQ-016 DIVZERO SHALL assert DivDoneE=1 for one cycle, leave HI/LO unchanged, -> IDLE.
REQ-017 Latency: accept edge T0; DONE occupies cycle 33 after T0; HI/LO valid from cycle 34.
REQ-018 DivBusyE SHALL be 1 when (IDLE and DivStartE=1 and FlushE=0) or state=RUN; 0 in DONE, DIVZERO and otherwise.
REQ-019 A new DivStartE SHALL not be accepted in DONE or DIVZERO (next acceptance only from IDLE).
REQ-020 FlushE=1 in any state SHALL force IDLE on the next edge, suppress DivDoneE, and block the divider's HI/LO write; FlushE has priority over DivStartE.
REQ-021 HiWeM/LoWeM SHALL write HI/LO on the edge when asserted, in any FSM state.
REQ-022 Simultaneous HiWeM/LoWeM and DONE write to the same register: divider result SHALL win (younger instruction in program order).
REQ-023 Signed 0x80000000 / 0xFFFFFFFF SHALL yield LO=0x80000000, HI=0x00000000 with no exception.
REQ-024 HiOut/LoOut SHALL be direct register outputs, no bypass of same-cycle writes.

Reset
REQ-025 reset=0 SHALL immediately set state IDLE, counter 0, HI=LO=0x00000000, DivBusyE=0, DivDoneE=0, independent of clock.
REQ-026 Reset asserted mid-RUN SHALL abandon the operation; no HI/LO write after release.
REQ-027 After reset deassertion the unit SHALL accept DivStartE on the first rising edge.

Verification
REQ-028 DIVU 100/7: DivStartE=1 -> DivBusyE=1 for 33 cycles, DivDoneE cycle 33, then LO=0x0000000E, HI=0x00000002.
REQ-029 DIV -7/2 (0xFFFFFFF9/0x00000002) -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-030 DIV 5/0 with HI=0x11, LO=0x22 -> DivBusyE 1 cycle, DivDoneE next cycle, HI=0x11, LO=0x22 unchanged.
REQ-031 FlushE=1 at RUN cycle 10 -> IDLE next edge, no DivDoneE, HI/LO unchanged, next DivStartE accepted normally.
REQ-032 HiWeM=1 with ALUOutHighM=0xAAAA0000 in DONE cycle of 9/4 -> HI=0x00000001, LO=0x00000002; HiWeM alone in IDLE -> HI=0xAAAA0000.
REQ-033 reset=0 at RUN cycle 20 -> all outputs zero immediately, no later write; DIV 0x80000000/0xFFFFFFFF afterwards -> LO=0x80000000, HI=0.
